div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 32 +++
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg -- definitions shared by the execute stage and the divider.
//   EXE_DIV_OP / EXE_DIVU_OP : execute-stage operation encodings. The execute
//                              stage decodes these into start/signed_div;
//                              the divider never looks at them.
//   DIV_W, DIV_ITERS         : operand width and restoring iteration count
//   div_state_e              : divider FSM states
//   abs32 / neg_if           : sign helpers used for operand latch and
//                              result correction
package div_unit_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    localparam logic [3:0] EXE_DIV_OP  = 4'b1010;
    localparam logic [3:0] EXE_DIVU_OP = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] abs32(input logic [DIV_W-1:0] v);
        return v[DIV_W-1] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIV_W-1:0] neg_if(input logic n, input logic [DIV_W-1:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one restoring division iteration, purely combinational.
//   i_prem    : 33-bit partial remainder, already shifted left with the next
//               dividend bit in bit 0
//   i_divisor : divisor magnitude
//   o_rem     : remainder after the trial subtract (restored if negative)
//   o_qbit    : quotient bit produced by this iteration
// The incoming remainder is always below the divisor, so the result fits in
// 32 bits and only the low word of the difference is needed.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DIV_W:0]   i_prem,
    input  logic [DIV_W-1:0] i_divisor,
    output logic [DIV_W-1:0] o_rem,
    output logic             o_qbit
);

    assign o_qbit = (i_prem >= {1'b0, i_divisor});
    assign o_rem  = o_qbit ? (i_prem[DIV_W-1:0] - i_divisor) : i_prem[DIV_W-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit restoring divider (DIV / DIVU).
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset
//   start      : request a division, accepted only when idle
//   signed_div : 1 = two's complement, 0 = unsigned; sampled with start
//   num1, num2 : dividend, divisor; sampled with start
//   annul      : synchronous abort, returns to idle on the next edge
//   busy       : operation in flight (RUN and DONE)
//   ready      : one-cycle pulse, hi/lo valid
//   hi, lo     : remainder, quotient; held until the next completion
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations
// and completes one cycle after start.
// Latency: start in cycle 0 -> RUN cycles 1..32 -> DONE (ready) in cycle 33.
module div_unit
    import div_unit_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [DIV_W-1:0] num1,
    input  logic [DIV_W-1:0] num2,
    input  logic             annul,
    output logic             busy,
    output logic             ready,
    output logic [DIV_W-1:0] hi,
    output logic [DIV_W-1:0] lo
);

    div_state_e             r_state;
    logic [DIV_CNT_W-1:0]   r_cnt;
    logic [DIV_W-1:0]       r_rem;   // partial remainder (upper word)
    logic [DIV_W-1:0]       r_quo;   // dividend bits shifting out, quotient bits in
    logic [DIV_W-1:0]       r_dvs;   // divisor magnitude
    logic                   r_qneg;
    logic                   r_rneg;
    logic                   r_dz;    // divisor was zero
    logic                   r_busy;
    logic                   r_ready;
    logic [DIV_W-1:0]       r_hi;
    logic [DIV_W-1:0]       r_lo;

    logic [DIV_W:0]         w_prem;
    logic [DIV_W-1:0]       w_next_rem;
    logic                   w_qbit;
    logic [DIV_W-1:0]       w_quo_next;
    logic [DIV_W-1:0]       w_a_mag;
    logic [DIV_W-1:0]       w_b_mag;
    logic [DIV_W-1:0]       w_lo_fin;
    logic [DIV_W-1:0]       w_hi_fin;
    logic                   w_num2_zero;

    assign w_a_mag     = signed_div ? abs32(num1) : num1;
    assign w_b_mag     = signed_div ? abs32(num2) : num2;
    assign w_num2_zero = (num2 == '0);

    assign w_prem     = {r_rem, r_quo[DIV_W-1]};
    assign w_quo_next = {r_quo[DIV_W-2:0], w_qbit};

    div_step u_step (
        .i_prem    (w_prem),
        .i_divisor (r_dvs),
        .o_rem     (w_next_rem),
        .o_qbit    (w_qbit)
    );

    // A zero divisor naturally yields an all-ones magnitude and the dividend
    // as remainder; the remainder correction then restores num1 exactly, but
    // the quotient must bypass sign correction to stay all-ones.
    assign w_lo_fin = r_dz ? '1 : neg_if(r_qneg, w_quo_next);
    assign w_hi_fin = neg_if(r_rneg, w_next_rem);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_ready <= 1'b0;
            if (annul) begin
                // Abort wins over start; results already registered stay.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_cnt  <= '0;
                            r_rem  <= '0;
                            r_quo  <= w_a_mag;
                            r_dvs  <= w_b_mag;
                            r_qneg <= signed_div & (num1[DIV_W-1] ^ num2[DIV_W-1]);
                            r_rneg <= signed_div & num1[DIV_W-1];
                            r_dz   <= w_num2_zero;
                            r_busy <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                            if (w_num2_zero) begin
                                r_state <= ST_DONE;
                                r_ready <= 1'b1;
                                r_lo    <= '1;
                                r_hi    <= num1;
                            end else begin
                                r_state <= ST_RUN;
                            end
`else
                            r_state <= ST_RUN;
`endif
                        end
                    end
                    ST_RUN: begin
                        r_rem <= w_next_rem;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == DIV_CNT_W'(DIV_ITERS - 1)) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                            r_lo    <= w_lo_fin;
                            r_hi    <= w_hi_fin;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy  = r_busy;
    assign ready = r_ready;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int vecs = 0;
    int errs = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .num1       (num1),
        .num2       (num2),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready; cyc carries the current cycle number.
    task automatic wait_rdy(input int cyc_in, output int cyc_out, output logic busy_ok);
        int c;
        logic b;
        c = cyc_in;
        b = 1'b1;
        while (!ready && c < 40) begin
            b &= busy;
            tick;
            c++;
        end
        b &= busy;
        cyc_out = c;
        busy_ok = b;
    endtask

    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int   cyc;
        logic bok;
        signed_div = sg;
        num1 = a;
        num2 = b;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_rdy(1, cyc, bok);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(bok), 32'd1);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_hi"}, hi, exp_hi);
        tick;
        chk({tag, "_idle"}, {30'd0, busy, ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic bok;
        logic seen;

        resetn = 1'b0;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        num1 = '0;
        num2 = '0;
        repeat (2) tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        resetn = 1'b1;
        tick;

        run_op("u100_7",   1'b0, 32'd100,      32'd7,        33,   32'd14,       32'd2);
        run_op("s_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        33,   32'hFFFFFFFD, 32'hFFFFFFFF);
        run_op("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2,        33,   32'h7FFFFFFC, 32'd1);
        run_op("s_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 33,   32'hFFFFFFFD, 32'd1);
        run_op("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33,   32'h80000000, 32'd0);
        run_op("dz_s",     1'b1, 32'h12345678, 32'd0,        ZLAT, 32'hFFFFFFFF, 32'h12345678);
        run_op("dz_u",     1'b0, 32'h12345678, 32'd0,        ZLAT, 32'hFFFFFFFF, 32'h12345678);
        run_op("dz_sneg",  1'b1, 32'h80000005, 32'd0,        ZLAT, 32'hFFFFFFFF, 32'h80000005);

        // Annul in cycle 10 of a run: idle next cycle, no ready, results held.
        signed_div = 1'b0;
        num1 = 32'd1000;
        num2 = 32'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        annul = 1'b1;
        tick;
        annul = 1'b0;
        chk("annul_busy", 32'(busy), 32'd0);
        seen = ready;
        repeat (40) begin
            tick;
            seen |= ready;
        end
        chk("annul_noready", 32'(seen), 32'd0);
        chk("annul_lo", lo, 32'hFFFFFFFF);
        chk("annul_hi", hi, 32'h80000005);

        // Annul beats a simultaneous start.
        num1 = 32'd9;
        num2 = 32'd2;
        start = 1'b1;
        annul = 1'b1;
        tick;
        start = 1'b0;
        annul = 1'b0;
        chk("annul_start_busy", 32'(busy), 32'd0);
        seen = ready;
        repeat (40) begin
            tick;
            seen |= ready;
        end
        chk("annul_start_noready", 32'(seen), 32'd0);

        // Start pulsed in cycle 5 of a run is ignored and not queued.
        num1 = 32'd50;
        num2 = 32'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        num1 = 32'd9;
        num2 = 32'd2;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_rdy(6, cyc, bok);
        chk("midstart_lat", 32'(cyc), 32'd33);
        chk("midstart_lo", lo, 32'd10);
        chk("midstart_hi", hi, 32'd0);
        tick;
        tick;
        chk("midstart_noqueue", {30'd0, busy, ready}, 32'd0);

        // Annul during DONE does not undo the completion.
        num1 = 32'd100;
        num2 = 32'd7;
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_rdy(1, cyc, bok);
        annul = 1'b1;
        chk("annul_done_ready", 32'(ready), 32'd1);
        tick;
        annul = 1'b0;
        chk("annul_done_lo", lo, 32'd14);
        chk("annul_done_hi", hi, 32'd2);
        chk("annul_done_busy", 32'(busy), 32'd0);

        // Reset in cycle 20: outputs cleared asynchronously, no late ready.
        num1 = 32'd1000;
        num2 = 32'd3;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (19) tick;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_outs", {busy, ready, 30'd0} | hi | lo, 32'd0);
        tick;
        tick;
        resetn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick;
            seen |= ready;
        end
        chk("rst_mid_noready", 32'(seen), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);

        run_op("post_rst", 1'b0, 32'd1000, 32'd3, 33, 32'd333, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
